vga_scanout: RTL and testbench
==============================

# vga_scanout

Parametrised VGA scan-out engine: generates programmable VGA timing from a single system clock via an internal pixel clock-enable and fetches pixels from the shared frame-buffer RAM. It adds integer pixel replication (upscaling) and frame-synchronous double-buffer swapping, and drives RGB out with syncs aligned to the data. It sits between the frame-buffer RAM read port and the board VGA connector.

## Interface
- ADDRW, 20, RAM address width
- DATAW, 12, RAM word width; pixel is {B[11:8], G[7:4], R[3:0]}
- CORDW, 10, screen coordinate counter width
- COLRW, 4, per-channel colour width
- CLK_DIV, 4, system clocks per pixel (100 MHz → 25 MHz)
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines
- SYNC_POL, 0, sync active level (0 = active-low)
- SCALE_SHIFT, 0, each frame-buffer pixel is replicated 2^SCALE_SHIFT times horizontally and vertically
- RAM_LAT, 1, clocks from ram_address/ram_enable to valid ram_data

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- fb_base  in  ADDRW  base address of the back buffer
- fb_swap_req  in  1  level request to display fb_base from the next frame
- fb_swap_ack  out  1  one-clk pulse when fb_base is taken
- frame_start  out  1  one-clk pulse on the pixel enable at sx=0, sy=0
- ram_address  out  ADDRW  read address
- ram_enable  out  1  read enable
- ram_data  in  DATAW  read data
- vga_hsync, vga_vsync  out  1  sync outputs
- vga_r, vga_g, vga_b  out  COLRW  colour outputs

## Operation
- Divider counts 0..CLK_DIV-1; pix_ce is high for one clk when the count equals CLK_DIV-1. All pixel-rate state advances only on pix_ce.
- sx counts 0..H_TOTAL-1 (H_TOTAL = sum of the H_* values). It wraps to 0 and then advances sy over 0..V_TOTAL-1, which also wraps to 0.
- de = (sx < H_ACTIVE) && (sy < V_ACTIVE). hsync is active for sx in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync follows the same rule in sy.
- Address generation is incremental, with no multiplier:
  - row_base advances by H_ACTIVE>>SCALE_SHIFT after every 2^SCALE_SHIFT active lines.
  - col advances by 1 after every 2^SCALE_SHIFT active pixels.
  - Both reset to 0 at frame start. col also resets at the start of each line.
- On a pix_ce where de=1: ram_address <= active_base + row_base + col, and ram_enable=1 for exactly one clk. On a pix_ce where de=0, ram_enable stays 0.
- ram_data is captured RAM_LAT clks after the enable into a pixel register.
- Frame start (pix_ce at sx=0, sy=0):
  - If fb_swap_req=1: active_base <= fb_base and fb_swap_ack pulses in the same clk.
  - Otherwise active_base is held.
  - A request raised mid-frame has no effect until the next frame start.
- Outputs update on pix_ce:
  - R = data[3:0], G = data[7:4], B = data[11:8], zero-extended or truncated to COLRW.
  - Colour is forced to 0 when the delayed de is 0.
- Reset (asynchronous, any time, including mid-frame):
  - Divider, sx, sy, row_base, col and active_base clear to 0.
  - ram_address = 0, ram_enable = 0, fb_swap_ack = 0, frame_start = 0.
  - Colour outputs = 0; syncs at the inactive level (!SYNC_POL).
  - After release, the first pix_ce is frame start.

## Timing
- Constraint: RAM_LAT + 1 ≤ CLK_DIV. Checked by an elaboration-time assertion.
- Pixel pipeline latency is exactly one pixel period:
  - Counter state at pix_ce n drives vga_* at pix_ce n+1.
  - hsync, vsync and de are delayed by one pixel period to stay aligned with colour.
- fb_swap_ack and frame_start pulse in the clk of the frame-start pix_ce. The new base is used for pixel (0,0) of that same frame.
- Output sync periods: hsync every H_TOTAL·CLK_DIV clks; vsync every V_TOTAL·H_TOTAL·CLK_DIV clks.

## Configuration
- VGA_SCANOUT_TEST_PATTERN_EN defined:
  - Adds input test_pattern (1 bit).
  - While it is high, colour comes from eight vertical bars, each H_ACTIVE/8 pixels wide. Bar k gives R/G/B all-ones when bit 0/1/2 of k is set.
  - RAM reads continue unchanged.
- Macro undefined: no test_pattern port; colour always comes from RAM.

## Test plan
- Reset: assert rst_n=0 mid-line → immediately vga_hsync=vga_vsync=1 and rgb=0; after release, first frame_start pulse occurs on the first pix_ce (clk 4 with defaults).
- Sync timing (defaults): hsync low for 384 clks in every 3200 clks; vsync low for 2 lines (6400 clks) in every 1,680,000 clks; frame_start once per frame.
- Data path: ram_data=0xABC returned for pixel (0,0) → one pixel later vga_r=0xC, vga_g=0xB, vga_b=0xA; all channels 0 throughout blanking and ram_enable never asserted there.
- Scaling, SCALE_SHIFT=1, base 0:
  - Line 0 pixels 0,1,2,3 → addresses 0,0,1,1.
  - Line 1 repeats line 0.
  - Line 2 pixel 0 → 320.
  - Last active pixel of the frame → 76799.
- Double buffer: fb_base=0x4B000 with fb_swap_req raised at line 100 → addresses keep the old base until frame end. fb_swap_ack pulses once with frame_start, and pixel (0,0) then reads 0x4B000. With req held low, no ack and the base is unchanged.
- VGA_SCANOUT_TEST_PATTERN_EN with test_pattern=1 → pixels 0–79 are black, 80–159 are red (R=0xF, G=B=0), and 560–639 are white.

Source files
------------

// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
//
// VGA scan-out engine. A clock divider produces a one-clk pixel enable
// (pix_ce) from the system clock. Pixel-rate counters (sx, sy) generate
// programmable VGA timing. Pixels are fetched from a frame-buffer RAM with
// incremental address generation and optional integer upscaling
// (2^SCALE_SHIFT replication in both directions). The displayed buffer base
// is swapped only at frame start. Syncs are delayed by one pixel period so
// they stay aligned with the colour pipeline.
//
// Optional feature macro: VGA_SCANOUT_TEST_PATTERN_EN
//   When defined, adds input test_pattern. While it is high, the colour comes
//   from eight vertical colour bars instead of RAM. RAM reads are unaffected.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   test_pattern in   colour-bar select (only with VGA_SCANOUT_TEST_PATTERN_EN)
//   fb_base      in   [ADDRW] base address of the back buffer
//   fb_swap_req  in   level request to display fb_base from the next frame
//   fb_swap_ack  out  one-clk pulse when fb_base is taken
//   frame_start  out  one-clk pulse on the pixel enable at sx=0, sy=0
//   ram_address  out  [ADDRW] RAM read address
//   ram_enable   out  RAM read enable (one clk per active pixel)
//   ram_data     in   [DATAW] RAM read data, {B[11:8], G[7:4], R[3:0]}
//   vga_hsync    out  horizontal sync
//   vga_vsync    out  vertical sync
//   vga_r/g/b    out  [COLRW] colour channels
// -----------------------------------------------------------------------------

// Elaboration-time check of the RAM latency against the pixel period.
module vga_scanout_param_check #(
    parameter int CLK_DIV = 4,
    parameter int RAM_LAT = 1
) ();
    if (RAM_LAT + 1 > CLK_DIV) begin : g_lat_too_long
        $error("vga_scanout: RAM_LAT + 1 must not exceed CLK_DIV");
    end
endmodule

module vga_scanout #(
    parameter int ADDRW       = 20,
    parameter int DATAW       = 12,
    parameter int CORDW       = 10,
    parameter int COLRW       = 4,
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int SCALE_SHIFT = 0,
    parameter int RAM_LAT     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic             test_pattern,
`endif
    input  logic [ADDRW-1:0] fb_base,
    input  logic             fb_swap_req,
    output logic             fb_swap_ack,
    output logic             frame_start,
    output logic [ADDRW-1:0] ram_address,
    output logic             ram_enable,
    input  logic [DATAW-1:0] ram_data,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic [COLRW-1:0] vga_r,
    output logic [COLRW-1:0] vga_g,
    output logic [COLRW-1:0] vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LAT_W   = RAM_LAT + 1;

    localparam logic [DIV_W-1:0] DIV_ZERO_C = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE_C  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(CLK_DIV - 1);

    localparam logic [CORDW-1:0] CORD_ZERO_C   = {CORDW{1'b0}};
    localparam logic [CORDW-1:0] CORD_ONE_C    = CORDW'(1);
    localparam logic [CORDW-1:0] H_ACT_C       = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] H_SYNC_BEG_C  = CORDW'(H_ACTIVE + H_FP);
    localparam logic [CORDW-1:0] H_SYNC_END_C  = CORDW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] H_LAST_C      = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_ACT_C       = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] V_SYNC_BEG_C  = CORDW'(V_ACTIVE + V_FP);
    localparam logic [CORDW-1:0] V_SYNC_END_C  = CORDW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CORDW-1:0] V_LAST_C      = CORDW'(V_TOTAL - 1);
    // Low SCALE_SHIFT bits all ones marks the last copy of a replicated pixel/line.
    localparam logic [CORDW-1:0] REP_MASK_C    = CORDW'((1 << SCALE_SHIFT) - 1);

    localparam logic [ADDRW-1:0] ADDR_ZERO_C = {ADDRW{1'b0}};
    localparam logic [ADDRW-1:0] ADDR_ONE_C  = ADDRW'(1);
    localparam logic [ADDRW-1:0] ROW_STEP_C  = ADDRW'(H_ACTIVE >> SCALE_SHIFT);

    localparam logic [COLRW-1:0] COL_ZERO_C = {COLRW{1'b0}};
    localparam logic [COLRW-1:0] COL_ONES_C = {COLRW{1'b1}};
    localparam logic [LAT_W-1:0] LAT_ZERO_C = {LAT_W{1'b0}};
    localparam logic             SYNC_ACT_C  = SYNC_POL;
    localparam logic             SYNC_IDLE_C = ~SYNC_POL;

    vga_scanout_param_check #(.CLK_DIV(CLK_DIV), .RAM_LAT(RAM_LAT)) u_param_check ();

    // Zero-extend or truncate a 4-bit channel to the output colour width.
    function automatic logic [COLRW-1:0] fit_colour(input logic [3:0] v);
        fit_colour = COLRW'(v);
    endfunction

    logic [DIV_W-1:0] div_r;
    logic [CORDW-1:0] sx_r, sy_r;
    logic [ADDRW-1:0] row_base_r, col_r, active_base_r, ram_address_r;
    logic [LAT_W-1:0] lat_r;
    logic [DATAW-1:0] pix_data_r;
    logic             frame_start_r, fb_swap_ack_r;
    logic             de_d_r, hs_d_r, vs_d_r;
    logic             hsync_r, vsync_r;
    logic [COLRW-1:0] r_r, g_r, b_r;

    logic             pix_ce_s, line_end_s, frame_end_s, de_s, hs_on_s, vs_on_s;
    logic             frame_first_s, swap_s, capture_s, col_step_s, row_step_s;
    logic [ADDRW-1:0] base_s, addr_s;
    logic [DATAW-1:0] src_data_s;
    logic [COLRW-1:0] r_s, g_s, b_s;

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [CORDW-1:0] BAR_LAST_C = CORDW'(BAR_W - 1);
    logic [CORDW-1:0] bar_px_r;
    logic [2:0]       bar_r, bar_d_r;
`endif

    assign pix_ce_s      = (div_r == DIV_LAST_C);
    assign line_end_s    = (sx_r == H_LAST_C);
    assign frame_end_s   = (sy_r == V_LAST_C);
    assign de_s          = (sx_r < H_ACT_C) && (sy_r < V_ACT_C);
    assign hs_on_s       = (sx_r >= H_SYNC_BEG_C) && (sx_r < H_SYNC_END_C);
    assign vs_on_s       = (sy_r >= V_SYNC_BEG_C) && (sy_r < V_SYNC_END_C);
    assign frame_first_s = (sx_r == CORD_ZERO_C) && (sy_r == CORD_ZERO_C);
    assign swap_s        = frame_first_s && fb_swap_req;
    assign col_step_s    = de_s && ((sx_r & REP_MASK_C) == REP_MASK_C);
    assign row_step_s    = (sy_r < V_ACT_C) && ((sy_r & REP_MASK_C) == REP_MASK_C);
    // The pixel returned by the RAM this clk, RAM_LAT clks after its enable.
    assign capture_s     = lat_r[RAM_LAT];

    // Base selection: a swap taken at frame start already applies to pixel (0,0).
    always_comb begin
        base_s = active_base_r;
        if (swap_s) begin
            base_s = fb_base;
        end else begin
            base_s = active_base_r;
        end
        addr_s = base_s + row_base_r + col_r;
    end

    // Pixel clock divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= DIV_ZERO_C;
        end else if (pix_ce_s) begin
            div_r <= DIV_ZERO_C;
        end else begin
            div_r <= div_r + DIV_ONE_C;
        end
    end

    // Screen position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_r <= CORD_ZERO_C;
            sy_r <= CORD_ZERO_C;
        end else if (pix_ce_s) begin
            if (line_end_s) begin
                sx_r <= CORD_ZERO_C;
                sy_r <= frame_end_s ? CORD_ZERO_C : sy_r + CORD_ONE_C;
            end else begin
                sx_r <= sx_r + CORD_ONE_C;
            end
        end
    end

    // Incremental frame-buffer row/column offsets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base_r <= ADDR_ZERO_C;
            col_r      <= ADDR_ZERO_C;
        end else if (pix_ce_s) begin
            if (line_end_s) begin
                col_r <= ADDR_ZERO_C;
                if (frame_end_s) begin
                    row_base_r <= ADDR_ZERO_C;
                end else if (row_step_s) begin
                    row_base_r <= row_base_r + ROW_STEP_C;
                end
            end else if (col_step_s) begin
                col_r <= col_r + ADDR_ONE_C;
            end
        end
    end

    // Displayed buffer base and frame-start handshake pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_base_r <= ADDR_ZERO_C;
            frame_start_r <= 1'b0;
            fb_swap_ack_r <= 1'b0;
        end else begin
            frame_start_r <= pix_ce_s && frame_first_s;
            fb_swap_ack_r <= pix_ce_s && swap_s;
            if (pix_ce_s && swap_s) begin
                active_base_r <= fb_base;
            end
        end
    end

    // RAM read request; lat_r[0] is the enable, higher bits track its latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_address_r <= ADDR_ZERO_C;
            lat_r         <= LAT_ZERO_C;
        end else begin
            lat_r <= (lat_r << 1) | LAT_W'(pix_ce_s && de_s);
            if (pix_ce_s && de_s) begin
                ram_address_r <= addr_s;
            end
        end
    end

    // Returned pixel capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_data_r <= {DATAW{1'b0}};
        end else if (capture_s) begin
            pix_data_r <= ram_data;
        end
    end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    // Colour-bar index for the current sx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_px_r <= CORD_ZERO_C;
            bar_r    <= 3'd0;
        end else if (pix_ce_s) begin
            if (line_end_s) begin
                bar_px_r <= CORD_ZERO_C;
                bar_r    <= 3'd0;
            end else if (bar_px_r == BAR_LAST_C) begin
                bar_px_r <= CORD_ZERO_C;
                bar_r    <= bar_r + 3'd1;
            end else begin
                bar_px_r <= bar_px_r + CORD_ONE_C;
            end
        end
    end
`endif

    // One-pixel delay of de/syncs so they line up with the fetched colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d_r <= 1'b0;
            hs_d_r <= SYNC_IDLE_C;
            vs_d_r <= SYNC_IDLE_C;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
            bar_d_r <= 3'd0;
`endif
        end else if (pix_ce_s) begin
            de_d_r <= de_s;
            hs_d_r <= hs_on_s ? SYNC_ACT_C : SYNC_IDLE_C;
            vs_d_r <= vs_on_s ? SYNC_ACT_C : SYNC_IDLE_C;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
            bar_d_r <= bar_r;
`endif
        end
    end

    // Colour selection; data arriving on the output edge itself is bypassed.
    always_comb begin
        src_data_s = pix_data_r;
        r_s = COL_ZERO_C;
        g_s = COL_ZERO_C;
        b_s = COL_ZERO_C;
        if (capture_s) begin
            src_data_s = ram_data;
        end else begin
            src_data_s = pix_data_r;
        end
        if (!de_d_r) begin
            r_s = COL_ZERO_C;
            g_s = COL_ZERO_C;
            b_s = COL_ZERO_C;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        end else if (test_pattern) begin
            r_s = bar_d_r[0] ? COL_ONES_C : COL_ZERO_C;
            g_s = bar_d_r[1] ? COL_ONES_C : COL_ZERO_C;
            b_s = bar_d_r[2] ? COL_ONES_C : COL_ZERO_C;
`endif
        end else begin
            r_s = fit_colour(src_data_s[3:0]);
            g_s = fit_colour(src_data_s[7:4]);
            b_s = fit_colour(src_data_s[11:8]);
        end
    end

    // Registered VGA outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_r <= SYNC_IDLE_C;
            vsync_r <= SYNC_IDLE_C;
            r_r     <= COL_ZERO_C;
            g_r     <= COL_ZERO_C;
            b_r     <= COL_ZERO_C;
        end else if (pix_ce_s) begin
            hsync_r <= hs_d_r;
            vsync_r <= vs_d_r;
            r_r     <= r_s;
            g_r     <= g_s;
            b_r     <= b_s;
        end
    end

    assign fb_swap_ack = fb_swap_ack_r;
    assign frame_start = frame_start_r;
    assign ram_address = ram_address_r;
    assign ram_enable  = lat_r[0];
    assign vga_hsync   = hsync_r;
    assign vga_vsync   = vsync_r;
    assign vga_r       = r_r;
    assign vga_g       = g_r;
    assign vga_b       = b_r;

endmodule

// File: tb/tb_vga_scanout.sv
// -----------------------------------------------------------------------------
// tb_vga_scanout
//
// Self-checking bench for vga_scanout using reduced timing so whole frames fit
// in a short run: 16x8 active, H_TOTAL=24, V_TOTAL=12, CLK_DIV=4,
// SCALE_SHIFT=1, RAM_LAT=1. The RAM model returns addr[11:0] + 0xABC one clk
// after each enable. Pixel p (counted from reset release) is fetched on clk
// edge 4*(p+1) and is shown on the VGA outputs four clks later.
// -----------------------------------------------------------------------------
module tb_vga_scanout;

    localparam int HT = 24;
    localparam int VT = 12;
    localparam int FRAME_PIX = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] fb_base = 20'h0;
    logic        fb_swap_req = 1'b0;
    logic        fb_swap_ack, frame_start, ram_enable;
    logic [19:0] ram_address;
    logic [11:0] ram_data = 12'h0;
    logic        vga_hsync, vga_vsync;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        test_pattern = 1'b0;

    int errors = 0;
    int checks = 0;
    int cur_clk = 0;

    vga_scanout #(
        .ADDRW(20), .DATAW(12), .CORDW(10), .COLRW(4), .CLK_DIV(4),
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .SCALE_SHIFT(1), .RAM_LAT(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .fb_base(fb_base),
        .fb_swap_req(fb_swap_req),
        .fb_swap_ack(fb_swap_ack),
        .frame_start(frame_start),
        .ram_address(ram_address),
        .ram_enable(ram_enable),
        .ram_data(ram_data),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] fmem(input logic [19:0] a);
        return a[11:0] + 12'hABC;
    endfunction

    // Frame-buffer RAM model, one clk latency.
    always @(posedge clk) begin
        if (ram_enable) ram_data <= fmem(ram_address);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step_clk(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
        cur_clk += n;
    endtask

    task automatic goto_pix(input int p);
        step_clk(4 * (p + 1) - cur_clk);
    endtask

    typedef struct {
        int         pix;
        logic       en;
        logic       chk_addr;
        logic [19:0] addr;
        logic       fs;
        logic       hs;
        logic       vs;
        logic [11:0] rgb;   // {r, g, b} of the previous pixel
    } vec_t;

    vec_t vecs[18];

    initial begin
        int p;
        int hs_low, vs_low, en_cnt, fs_cnt, per;
        logic prev_hs;
        bit found;

        vecs[0]  = '{0,   1'b1, 1'b1, 20'd0,  1'b1, 1'b1, 1'b1, 12'h000};
        vecs[1]  = '{1,   1'b1, 1'b1, 20'd0,  1'b0, 1'b1, 1'b1, 12'hCBA};
        vecs[2]  = '{2,   1'b1, 1'b1, 20'd1,  1'b0, 1'b1, 1'b1, 12'hCBA};
        vecs[3]  = '{3,   1'b1, 1'b1, 20'd1,  1'b0, 1'b1, 1'b1, 12'hDBA};
        vecs[4]  = '{16,  1'b0, 1'b0, 20'd0,  1'b0, 1'b1, 1'b1, 12'h3CA};
        vecs[5]  = '{17,  1'b0, 1'b0, 20'd0,  1'b0, 1'b1, 1'b1, 12'h000};
        vecs[6]  = '{19,  1'b0, 1'b0, 20'd0,  1'b0, 1'b0, 1'b1, 12'h000};
        vecs[7]  = '{22,  1'b0, 1'b0, 20'd0,  1'b0, 1'b1, 1'b1, 12'h000};
        vecs[8]  = '{24,  1'b1, 1'b1, 20'd0,  1'b0, 1'b1, 1'b1, 12'h000};
        vecs[9]  = '{27,  1'b1, 1'b1, 20'd1,  1'b0, 1'b1, 1'b1, 12'hDBA};
        vecs[10] = '{48,  1'b1, 1'b1, 20'd8,  1'b0, 1'b1, 1'b1, 12'h000};
        vecs[11] = '{49,  1'b1, 1'b1, 20'd8,  1'b0, 1'b1, 1'b1, 12'h4CA};
        vecs[12] = '{183, 1'b1, 1'b1, 20'd31, 1'b0, 1'b1, 1'b1, 12'hBDA};
        vecs[13] = '{184, 1'b0, 1'b0, 20'd0,  1'b0, 1'b1, 1'b1, 12'hBDA};
        vecs[14] = '{221, 1'b0, 1'b0, 20'd0,  1'b0, 1'b1, 1'b0, 12'h000};
        vecs[15] = '{265, 1'b0, 1'b0, 20'd0,  1'b0, 1'b1, 1'b1, 12'h000};
        vecs[16] = '{288, 1'b1, 1'b1, 20'd0,  1'b1, 1'b1, 1'b1, 12'h000};
        vecs[17] = '{289, 1'b1, 1'b1, 20'd0,  1'b0, 1'b1, 1'b1, 12'hCBA};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hsync", vga_hsync, 1'b1);
        chk("rst_vsync", vga_vsync, 1'b1);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("rst_en", ram_enable, 1'b0);
        chk("rst_addr", ram_address, 20'h0);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_ack", fb_swap_ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cur_clk = 0;

        // Table-driven checks over the first frame and a half
        for (int i = 0; i < 18; i++) begin
            goto_pix(vecs[i].pix);
            chk($sformatf("vec%0d_en", i), ram_enable, vecs[i].en);
            if (vecs[i].chk_addr) chk($sformatf("vec%0d_addr", i), ram_address, vecs[i].addr);
            chk($sformatf("vec%0d_fs", i), frame_start, vecs[i].fs);
            chk($sformatf("vec%0d_hs", i), vga_hsync, vecs[i].hs);
            chk($sformatf("vec%0d_vs", i), vga_vsync, vecs[i].vs);
            chk($sformatf("vec%0d_rgb", i), {vga_r, vga_g, vga_b}, vecs[i].rgb);
        end
        step_clk(1);
        chk("en_one_clk", ram_enable, 1'b0);

        // Double buffer: request mid-frame, taken at next frame start
        goto_pix(FRAME_PIX + 4 * HT);
        fb_base = 20'h4B000;
        fb_swap_req = 1'b1;
        goto_pix(FRAME_PIX + 5 * HT + 2);
        chk("swap_old_base_addr", ram_address, 20'd17);
        chk("swap_no_early_ack", fb_swap_ack, 1'b0);
        goto_pix(2 * FRAME_PIX - 1);
        chk("swap_no_ack_end", fb_swap_ack, 1'b0);
        goto_pix(2 * FRAME_PIX);
        chk("swap_fs", frame_start, 1'b1);
        chk("swap_ack", fb_swap_ack, 1'b1);
        chk("swap_new_addr", ram_address, 20'h4B000);
        step_clk(1);
        chk("swap_ack_pulse", fb_swap_ack, 1'b0);
        chk("swap_fs_pulse", frame_start, 1'b0);
        fb_swap_req = 1'b0;
        goto_pix(2 * FRAME_PIX + 1);
        chk("swap_pix1_addr", ram_address, 20'h4B000);
        chk("swap_pix0_rgb", {vga_r, vga_g, vga_b}, 12'hCBA);
        fb_base = 20'h12345;
        goto_pix(3 * FRAME_PIX);
        chk("noswap_fs", frame_start, 1'b1);
        chk("noswap_ack", fb_swap_ack, 1'b0);
        chk("noswap_addr", ram_address, 20'h4B000);
        goto_pix(3 * FRAME_PIX + HT + 2);
        chk("noswap_line1_addr", ram_address, 20'h4B001);

        // Frame-level counts over one full frame of clocks
        hs_low = 0; vs_low = 0; en_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 4 * FRAME_PIX; i++) begin
            step_clk(1);
            if (!vga_hsync) hs_low++;
            if (!vga_vsync) vs_low++;
            if (ram_enable) en_cnt++;
            if (frame_start) fs_cnt++;
        end
        chk("frame_hs_low_clks", hs_low, 144);
        chk("frame_vs_low_clks", vs_low, 192);
        chk("frame_en_count", en_cnt, 128);
        chk("frame_fs_count", fs_cnt, 1);

        // hsync period: falling edge to falling edge
        found = 1'b0;
        prev_hs = vga_hsync;
        for (int i = 0; i < 200 && !found; i++) begin
            step_clk(1);
            if (prev_hs && !vga_hsync) found = 1'b1;
            prev_hs = vga_hsync;
        end
        chk("hs_first_fall_seen", found, 1'b1);
        per = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step_clk(1);
            per++;
            if (prev_hs && !vga_hsync) found = 1'b1;
            prev_hs = vga_hsync;
        end
        chk("hs_period", per, 4 * HT);

        // Asynchronous reset in the middle of a line, during hsync
        p = ((cur_clk / 4) / HT + 1) * HT + 20;
        goto_pix(p);
        chk("pre_rst_hsync_active", vga_hsync, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_hsync", vga_hsync, 1'b1);
        chk("async_rst_vsync", vga_vsync, 1'b1);
        chk("async_rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("async_rst_en", ram_enable, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cur_clk = 0;
        step_clk(3);
        chk("rel_fs_early", frame_start, 1'b0);
        step_clk(1);
        chk("rel_fs_clk4", frame_start, 1'b1);
        chk("rel_en_clk4", ram_enable, 1'b1);
        chk("rel_addr_base0", ram_address, 20'h0);

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        // Colour bars, two pixels wide with this timing
        test_pattern = 1'b1;
        goto_pix(1);
        chk("tp_bar0_black", {vga_r, vga_g, vga_b}, 12'h000);
        goto_pix(3);
        chk("tp_bar1_red", {vga_r, vga_g, vga_b}, 12'hF00);
        goto_pix(15);
        chk("tp_bar7_white", {vga_r, vga_g, vga_b}, 12'hFFF);
        chk("tp_ram_still_read", ram_enable, 1'b1);
        test_pattern = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
